// File: rtl/alu_input_sequencer.sv
// Operand/opcode loader for the 16-bit ALU: loads A, B and op from the switches, pulses start,
// then captures the result and flags into hold registers for the display.
module alu_input_sequencer #(
  parameter int WIDTH        = 16,
  parameter int OP_WIDTH     = 4,
  parameter int START_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    sw,
  input  logic                btn_load,
  input  logic                btn_clear,
  output logic [WIDTH-1:0]    a,
  output logic [WIDTH-1:0]    b,
  output logic [OP_WIDTH-1:0] op,
  output logic                start,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic                alu_c,
  input  logic                alu_v,
  output logic [WIDTH-1:0]    res_q,
  output logic [3:0]          flags_q,
  output logic                res_valid,
  output logic [2:0]          state_dbg
);

  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] SHOW    = 3'd5;

  localparam logic [7:0] CNT_INIT = 8'(START_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic       load_pulse;
  logic       clear_pulse;

  assign btn_raw     = {btn_clear, btn_load};
  assign load_pulse  = btn_pulse[0];
  assign clear_pulse = btn_pulse[1];

  // Each button: two-flop synchroniser followed by a rising-edge detector.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_reg;
      logic sync2_reg;
      logic prev_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          prev_reg  <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
        end
      end

      assign btn_pulse[gi] = sync2_reg & ~prev_reg;
    end
  endgenerate

  logic [2:0]          state_reg, state_next;
  logic [WIDTH-1:0]    a_reg, a_next;
  logic [WIDTH-1:0]    b_reg, b_next;
  logic [OP_WIDTH-1:0] op_reg, op_next;
  logic                start_reg, start_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [WIDTH-1:0]    res_reg, res_next;
  logic [3:0]          flags_reg, flags_next;
  logic                valid_reg, valid_next;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    start_next = start_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;
    flags_next = flags_reg;
    valid_next = valid_reg;

    // Clear overrides everything, including a simultaneous load.
    if (clear_pulse) begin
      state_next = LOAD_A;
      a_next     = '0;
      b_next     = '0;
      op_next    = '0;
      start_next = 1'b0;
      cnt_next   = '0;
      res_next   = '0;
      flags_next = '0;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        LOAD_A: begin
          if (load_pulse) begin
            a_next     = sw;
            state_next = LOAD_B;
          end
        end
        LOAD_B: begin
          if (load_pulse) begin
            b_next     = sw;
            state_next = LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (load_pulse) begin
            op_next    = sw[OP_WIDTH-1:0];
            cnt_next   = CNT_INIT;
            start_next = 1'b1;
            state_next = RUN;
          end
        end
        RUN: begin
          if (cnt_reg == 8'd0) begin
            start_next = 1'b0;
            state_next = CAPTURE;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        CAPTURE: begin
          res_next   = alu_result;
          flags_next = {alu_n, alu_z, alu_c, alu_v};
          valid_next = 1'b1;
          state_next = SHOW;
        end
        SHOW: begin
          // Previous result stays valid while the next operation is loaded.
          if (load_pulse) begin
            a_next     = sw;
            state_next = LOAD_B;
          end
        end
        default: begin
          start_next = 1'b0;
          state_next = LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD_A;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      start_reg <= 1'b0;
      cnt_reg   <= '0;
      res_reg   <= '0;
      flags_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      start_reg <= start_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
      flags_reg <= flags_next;
      valid_reg <= valid_next;
    end
  end

  assign a         = a_reg;
  assign b         = b_reg;
  assign op        = op_reg;
  assign start     = start_reg;
  assign res_q     = res_reg;
  assign flags_q   = flags_reg;
  assign res_valid = valid_reg;
  assign state_dbg = state_reg;

endmodule
